gen_stream_reducer: RTL and testbench

// Downstream consumer/controller for a generator-style stream stage (n/__start in; __valid/__ready/__done/__output_0 out).

---
 rtl/p2v_stream_pkg.sv | 17 +
 rtl/stream_accumulator.sv | 56 +++++
 rtl/gen_stream_reducer.sv | 108 ++++++++++
 tb/tb_gen_stream_reducer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/p2v_stream_pkg.sv
// Shared types and default widths for the generator-stream reducer.
//   reducer_state_t : controller states IDLE -> LAUNCH -> COLLECT -> EMIT
//   *_DEF           : default widths for the data, sum and beat-count paths
package p2v_stream_pkg;

    localparam int W_DEF     = 32;
    localparam int SUM_W_DEF = 64;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        COLLECT = 2'd2,
        EMIT    = 2'd3
    } reducer_state_t;

endpackage

// File: rtl/stream_accumulator.sv
// Running sum / saturating count / unsigned max over a stream of data beats.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero all accumulators (start of a new run)
//   en, data  : accumulate one data beat
//   sum       : sum of beats mod 2^SUM_W
//   count     : number of beats, saturating at all-ones
//   max       : unsigned max of beats, 0 when no beats
//   overflow  : sticky; sum carried out or count hit saturation
module stream_accumulator
    import p2v_stream_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int SUM_W = SUM_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [W-1:0]     data,
    output logic [SUM_W-1:0] sum,
    output logic [CNT_W-1:0] count,
    output logic [W-1:0]     max,
    output logic             overflow
);

    // One extra bit catches the carry-out of the unsigned add.
    logic [SUM_W:0] sum_ext;
    logic           cnt_full;

    assign sum_ext  = {1'b0, sum} + {{(SUM_W + 1 - W){1'b0}}, data};
    assign cnt_full = &count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            count    <= '0;
            max      <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            sum      <= '0;
            count    <= '0;
            max      <= '0;
            overflow <= 1'b0;
        end else if (en) begin
            sum <= sum_ext[SUM_W-1:0];
            if (!cnt_full)
                count <= count + CNT_W'(1);
            if (data > max)
                max <= data;
            // A beat arriving with the counter already full is a lost count.
            overflow <= overflow | sum_ext[SUM_W] | cnt_full;
        end
    end

endmodule

// File: rtl/gen_stream_reducer.sv
// Controller that launches one generator run, reduces every yielded beat to
// sum/count/max and hands the result downstream as a single valid/ready beat.
//   __clock, __reset       : clock, asynchronous active-high reset
//   n, __start             : run argument and run request (taken only in IDLE)
//   __ready, __valid       : result handshake to the next stage
//   __done                 : one-cycle pulse after the result is accepted
//   __output_sum/count/max : reduced result, stable while __valid
//   __overflow             : sum wrapped or count saturated in that run
//   gen_n, gen_start       : argument and one-cycle start to the generator
//   gen_ready              : high only while collecting
//   gen_valid, gen_done,
//   gen_data               : generator beat; valid&done is a terminator
module gen_stream_reducer
    import p2v_stream_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int SUM_W = SUM_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             __clock,
    input  logic             __reset,
    input  logic [W-1:0]     n,
    input  logic             __start,
    input  logic             __ready,
    output logic             __valid,
    output logic             __done,
    output logic [SUM_W-1:0] __output_sum,
    output logic [CNT_W-1:0] __output_count,
    output logic [W-1:0]     __output_max,
    output logic             __overflow,
    output logic [W-1:0]     gen_n,
    output logic             gen_start,
    output logic             gen_ready,
    input  logic             gen_valid,
    input  logic             gen_done,
    input  logic [W-1:0]     gen_data
);

    reducer_state_t   state;
    logic             acc_clear;
    logic             acc_en;
    logic [SUM_W-1:0] acc_sum;
    logic [CNT_W-1:0] acc_count;
    logic [W-1:0]     acc_max;
    logic             acc_ovf;

    assign gen_start = (state == LAUNCH);
    assign gen_ready = (state == COLLECT);
    assign acc_clear = (state == IDLE) && __start;
    // Upstream beats outside COLLECT are ignored; the terminator's data is a sentinel.
    assign acc_en    = (state == COLLECT) && gen_valid && !gen_done;

    stream_accumulator #(.W(W), .SUM_W(SUM_W), .CNT_W(CNT_W)) u_acc (
        .clk      (__clock),
        .rst      (__reset),
        .clear    (acc_clear),
        .en       (acc_en),
        .data     (gen_data),
        .sum      (acc_sum),
        .count    (acc_count),
        .max      (acc_max),
        .overflow (acc_ovf)
    );

    always_ff @(posedge __clock or posedge __reset) begin
        if (__reset) begin
            state          <= IDLE;
            gen_n          <= '0;
            __valid        <= 1'b0;
            __done         <= 1'b0;
            __output_sum   <= '0;
            __output_count <= '0;
            __output_max   <= '0;
            __overflow     <= 1'b0;
        end else begin
            __done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (__start) begin
                        gen_n <= n;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: state <= COLLECT;
                COLLECT: begin
                    if (gen_valid && gen_done) begin
                        __output_sum   <= acc_sum;
                        __output_count <= acc_count;
                        __output_max   <= acc_max;
                        __overflow     <= acc_ovf;
                        __valid        <= 1'b1;
                        state          <= EMIT;
                    end
                end
                EMIT: begin
                    // __start here is dropped: IDLE is only entered after this edge.
                    if (__ready) begin
                        __valid <= 1'b0;
                        __done  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_stream_reducer.sv
// Scoreboard bench for gen_stream_reducer: runs push expected results into a
// queue, a monitor pops and compares on every accepted result beat.
module tb_gen_stream_reducer;

    localparam int W     = 32;
    localparam int SUM_W = 32;
    localparam int CNT_W = 3;

    typedef struct {
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic [W-1:0]     max;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     n;
    logic             start;
    logic             rdy;
    logic             valid;
    logic             done;
    logic [SUM_W-1:0] osum;
    logic [CNT_W-1:0] ocnt;
    logic [W-1:0]     omax;
    logic             ovf;
    logic [W-1:0]     gen_n;
    logic             gen_start;
    logic             gen_ready;
    logic             gv;
    logic             gd;
    logic [W-1:0]     gdata;

    exp_t         exp_q[$];
    logic [W-1:0] bq[$];
    int           applied    = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    gen_stream_reducer #(.W(W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .__clock        (clk),
        .__reset        (rst),
        .n              (n),
        .__start        (start),
        .__ready        (rdy),
        .__valid        (valid),
        .__done         (done),
        .__output_sum   (osum),
        .__output_count (ocnt),
        .__output_max   (omax),
        .__overflow     (ovf),
        .gen_n          (gen_n),
        .gen_start      (gen_start),
        .gen_ready      (gen_ready),
        .gen_valid      (gv),
        .gen_done       (gd),
        .gen_data       (gdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        applied++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one generator run from bq; returns edges from start to __valid.
    task automatic run(input logic [W-1:0] arg, input int gapmax,
                       input logic [W-1:0] sentinel, output int lat);
        exp_t        e;
        logic [32:0] s;
        int          k;
        s = '0;
        e.count = '0;
        e.max   = '0;
        e.ovf   = 1'b0;
        foreach (bq[i]) begin
            s = {1'b0, s[31:0]} + {1'b0, bq[i]};
            if (s[32]) e.ovf = 1'b1;
            if (e.count == 3'd7) e.ovf = 1'b1;
            else e.count = e.count + 3'd1;
            if (bq[i] > e.max) e.max = bq[i];
        end
        e.sum = s[31:0];

        n = arg; start = 1'b1;
        step(); lat = 1;
        start = 1'b0;
        check("gen_start_launch", 64'(gen_start), 64'd1);
        k = 0;
        while (!gen_ready && k < 8) begin step(); lat++; k++; end
        check("gen_ready_collect", 64'(gen_ready), 64'd1);
        check("gen_n_held", 64'(gen_n), 64'(arg));
        foreach (bq[i]) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            repeat (g) begin
                gv = 1'b0;
                step(); lat++;
                check("gen_ready_gap", 64'(gen_ready), 64'd1);
            end
            gv = 1'b1; gd = 1'b0; gdata = bq[i];
            step(); lat++;
            gv = 1'b0;
        end
        exp_q.push_back(e);
        gv = 1'b1; gd = 1'b1; gdata = sentinel;
        step(); lat++;
        gv = 1'b0; gd = 1'b0; gdata = '0;
        check("valid_after_term", 64'(valid), 64'd1);
    endtask

    // Monitor: compare every accepted result beat, then the __done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && valid && rdy) begin
                if (exp_q.size() == 0) begin
                    applied++; miscompares++;
                    $display("FAIL unexpected_result: got sum 0x%0h with no expected entry", osum);
                end else begin
                    e = exp_q.pop_front();
                    check("result_sum",   64'(osum), 64'(e.sum));
                    check("result_count", 64'(ocnt), 64'(e.count));
                    check("result_max",   64'(omax), 64'(e.max));
                    check("result_ovf",   64'(ovf),  64'(e.ovf));
                    @(negedge clk);
                    check("done_pulse",    64'(done),  64'd1);
                    check("valid_dropped", 64'(valid), 64'd0);
                    @(negedge clk);
                    check("done_one_cycle", 64'(done), 64'd0);
                end
            end
        end
    end

    initial begin
        int lat;
        int k;
        rst = 1'b1; n = '0; start = 1'b0; rdy = 1'b1;
        gv = 1'b0; gd = 1'b0; gdata = '0;
        #1;
        check("rst_valid",     64'(valid),     64'd0);
        check("rst_done",      64'(done),      64'd0);
        check("rst_sum",       64'(osum),      64'd0);
        check("rst_gen_start", 64'(gen_start), 64'd0);
        check("rst_gen_ready", 64'(gen_ready), 64'd0);
        step(); step();
        rst = 1'b0;
        step();

        // 1: terminator only
        bq = {};
        run(32'd0, 0, 32'd0, lat);
        check("min_latency", 64'(lat), 64'd3);
        repeat (4) step();

        // stale upstream valid in IDLE must not accumulate
        gv = 1'b1; gdata = 32'd100;
        step(); check("idle_gen_ready", 64'(gen_ready), 64'd0);
        step(); step();
        gv = 1'b0; gdata = '0;

        // 2: 1,1,3,5
        bq = {32'd1, 32'd1, 32'd3, 32'd5};
        run(32'd4, 0, 32'd0, lat);
        repeat (4) step();

        // 3: gapped beats 7,2,9 with nonzero sentinel
        bq = {32'd7, 32'd2, 32'd9};
        run(32'd3, 3, 32'hDEAD_BEEF, lat);
        repeat (4) step();

        // 4: hold result under backpressure, poke __start
        rdy = 1'b0;
        bq = {32'd10, 32'd20};
        run(32'd2, 0, 32'hDEAD_BEEF, lat);
        for (int i = 0; i < 5; i++) begin
            start = ~start;
            step();
            check("hold_gen_start", 64'(gen_start), 64'd0);
            check("hold_valid",     64'(valid),     64'd1);
            check("hold_sum",       64'(osum),      64'd30);
            check("hold_done",      64'(done),      64'd0);
        end
        start = 1'b1; rdy = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_relaunch_start", 64'(gen_start), 64'd0);
            check("no_relaunch_ready", 64'(gen_ready), 64'd0);
        end

        // 5: sum wrap sets overflow, next run clears it
        bq = {32'hFFFF_FFFF, 32'd2};
        run(32'd2, 0, 32'hDEAD_BEEF, lat);
        repeat (4) step();
        bq = {32'd4};
        run(32'd1, 0, 32'hDEAD_BEEF, lat);
        repeat (4) step();

        // count saturation at CNT_W=3: eight beats of 1
        bq = {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
        run(32'd8, 0, 32'hDEAD_BEEF, lat);
        repeat (4) step();

        // 6: reset mid-collect after two beats
        n = 32'd5; start = 1'b1;
        step(); start = 1'b0;
        k = 0;
        while (!gen_ready && k < 8) begin step(); k++; end
        check("abort_gen_ready", 64'(gen_ready), 64'd1);
        gv = 1'b1; gdata = 32'd3; step();
        gdata = 32'd4; step();
        gv = 1'b0; gdata = '0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(valid),     64'd0);
        check("mid_rst_sum",   64'(osum),      64'd0);
        check("mid_rst_count", 64'(ocnt),      64'd0);
        check("mid_rst_max",   64'(omax),      64'd0);
        check("mid_rst_ovf",   64'(ovf),       64'd0);
        check("mid_rst_gen_n", 64'(gen_n),     64'd0);
        check("mid_rst_ready", 64'(gen_ready), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", 64'(gen_ready), 64'd0);
        bq = {32'd6};
        run(32'd1, 0, 32'hDEAD_BEEF, lat);

        k = 0;
        while (exp_q.size() != 0 && k < 50) begin step(); k++; end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
